// File: rtl/aes128_ctr_block_packer.sv
// Packs a byte stream into 128-bit blocks for the AES-128 CTR stage; start pulse one cycle after the closing byte.
// Byte input is stalled (ready low) from block issue until the CTR stage reports done, and forever once the index is exhausted.
module aes128_ctr_block_packer #(
  parameter int IDX_W = 8
) (
  input  logic             pi_clk,
  input  logic             pi_rst,
  input  logic [7:0]       pi_byte_data,
  input  logic             pi_byte_valid,
  input  logic             pi_byte_last,
  output logic             po_byte_ready,
  input  logic             pi_done,
  output logic [127:0]     po_block_data,
  output logic [15:0]      po_block_mask,
  output logic             po_block_last,
  output logic [IDX_W-1:0] po_block_idx,
  output logic             po_start,
  output logic             po_busy,
  output logic             po_overflow
);

  typedef enum logic [1:0] {
    S_FILL,
    S_ISSUE,
    S_WAIT,
    S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [3:0]       cnt_q;
  logic [127:0]     data_q;
  logic [15:0]      mask_q;
  logic             last_q;
  logic [IDX_W-1:0] idx_q;
  logic             ovf_q;

  logic accept;
  logic fill_done;
  logic wait_done;
  logic ready_c;
  logic start_c;
  logic busy_c;

  always_ff @(posedge pi_clk) begin
    if (pi_rst) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    fill_done = 1'b0;
    wait_done = 1'b0;
    ready_c   = 1'b0;
    start_c   = 1'b0;
    busy_c    = 1'b0;
    case (state_q)
      S_FILL: begin
        ready_c = 1'b1;
        if (pi_byte_valid) begin
          accept = 1'b1;
          if (cnt_q == 4'd15 || pi_byte_last) begin
            fill_done = 1'b1;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        start_c = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        busy_c = 1'b1;
        if (pi_done) begin
          wait_done = 1'b1;
          if (last_q) begin
            state_d = S_FILL;
          end else if (idx_q == {IDX_W{1'b1}}) begin
            state_d = S_HALT;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  always_ff @(posedge pi_clk) begin
    if (pi_rst) begin
      cnt_q  <= '0;
      data_q <= '0;
      mask_q <= '0;
      last_q <= 1'b0;
      idx_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < 16; i++) begin
          if (cnt_q == 4'(i)) begin
            data_q[8*(15-i) +: 8] <= pi_byte_data;
            mask_q[15-i]          <= 1'b1;
          end
        end
        cnt_q <= cnt_q + 4'd1;
      end
      if (fill_done) begin
        last_q <= pi_byte_last;
      end
      if (wait_done) begin
        cnt_q  <= '0;
        data_q <= '0;
        mask_q <= '0;
        last_q <= 1'b0;
        // A saturated index is kept rather than wrapped so the counter is never reused.
        if (last_q) begin
          idx_q <= '0;
        end else if (idx_q == {IDX_W{1'b1}}) begin
          ovf_q <= 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  // Outputs read zero throughout reset, including the first reset cycle before registers clear.
  assign po_byte_ready = ready_c & ~pi_rst;
  assign po_start      = start_c & ~pi_rst;
  assign po_busy       = busy_c & ~pi_rst;
  assign po_block_data = pi_rst ? '0 : data_q;
  assign po_block_mask = pi_rst ? '0 : mask_q;
  assign po_block_last = last_q & ~pi_rst;
  assign po_block_idx  = pi_rst ? '0 : idx_q;
  assign po_overflow   = ovf_q & ~pi_rst;

endmodule

// File: tb/tb_aes128_ctr_block_packer.sv
// Randomized bench for aes128_ctr_block_packer against a byte-list reference model.
module tb_aes128_ctr_block_packer;

  logic         pi_clk = 1'b0;
  logic         pi_rst;
  logic [7:0]   pi_byte_data;
  logic         pi_byte_valid;
  logic         pi_byte_last;
  logic         po_byte_ready;
  logic         pi_done;
  logic [127:0] po_block_data;
  logic [15:0]  po_block_mask;
  logic         po_block_last;
  logic [7:0]   po_block_idx;
  logic         po_start;
  logic         po_busy;
  logic         po_overflow;

  always #5 pi_clk = ~pi_clk;

  aes128_ctr_block_packer #(.IDX_W(8)) dut (
    .pi_clk        (pi_clk),
    .pi_rst        (pi_rst),
    .pi_byte_data  (pi_byte_data),
    .pi_byte_valid (pi_byte_valid),
    .pi_byte_last  (pi_byte_last),
    .po_byte_ready (po_byte_ready),
    .pi_done       (pi_done),
    .po_block_data (po_block_data),
    .po_block_mask (po_block_mask),
    .po_block_last (po_block_last),
    .po_block_idx  (po_block_idx),
    .po_start      (po_start),
    .po_busy       (po_busy),
    .po_overflow   (po_overflow)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: next block index and sticky overflow.
  int exp_idx = 0;
  bit exp_ovf = 1'b0;

  logic [7:0] blk [16];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge pi_clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 128'(po_byte_ready), 128'(0));
    chk({tag, "_start"}, 128'(po_start), 128'(0));
    chk({tag, "_busy"},  128'(po_busy), 128'(0));
    chk({tag, "_data"},  po_block_data, 128'(0));
    chk({tag, "_mask"},  128'(po_block_mask), 128'(0));
    chk({tag, "_last"},  128'(po_block_last), 128'(0));
    chk({tag, "_idx"},   128'(po_block_idx), 128'(0));
    chk({tag, "_ovf"},   128'(po_overflow), 128'(0));
  endtask

  task automatic pulse_done();
    pi_done = 1'b1;
    tick();
    pi_done = 1'b0;
  endtask

  // Present one byte and hold it until a clock edge with ready high takes it.
  task automatic send_byte(input logic [7:0] b, input bit last);
    int t;
    t = 0;
    pi_byte_valid = 1'b1;
    pi_byte_data  = b;
    pi_byte_last  = last;
    while (!po_byte_ready && t < 200) begin
      tick();
      t++;
    end
    if (!po_byte_ready) chk("ready_timeout", 128'(po_byte_ready), 128'(1));
    tick();
    pi_byte_valid = 1'b0;
    pi_byte_last  = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) blk[i] = 8'($urandom_range(0, 255));
  endtask

  // Send blk[0..len-1] as one block, check issue/wait/done behaviour, update the model.
  task automatic run_block(input int len, input bit last, input int dly,
                           input bit spur_issue, input bit hold55);
    logic [127:0] ed;
    logic [15:0]  em;
    ed = '0;
    em = '0;
    for (int i = 0; i < len; i++) begin
      ed = ed | (128'(blk[i]) << (8 * (15 - i)));
      em = em | (16'h8000 >> i);
    end
    for (int i = 0; i < len; i++) send_byte(blk[i], last && (i == len - 1));
    chk("issue_start", 128'(po_start), 128'(1));
    chk("issue_ready", 128'(po_byte_ready), 128'(0));
    chk("issue_busy",  128'(po_busy), 128'(0));
    chk("issue_mask",  128'(po_block_mask), 128'(em));
    if (spur_issue) pi_done = 1'b1;
    if (hold55) begin
      pi_byte_valid = 1'b1;
      pi_byte_data  = 8'h55;
      pi_byte_last  = 1'b0;
    end
    tick();
    pi_done = 1'b0;
    chk("wait_start", 128'(po_start), 128'(0));
    chk("wait_busy",  128'(po_busy), 128'(1));
    chk("wait_data",  po_block_data, ed);
    chk("wait_mask",  128'(po_block_mask), 128'(em));
    chk("wait_last",  128'(po_block_last), 128'(last));
    chk("wait_idx",   128'(po_block_idx), 128'(exp_idx));
    repeat (dly) tick();
    chk("hold_busy",  128'(po_busy), 128'(1));
    chk("hold_ready", 128'(po_byte_ready), 128'(0));
    chk("hold_start", 128'(po_start), 128'(0));
    chk("hold_data",  po_block_data, ed);
    chk("hold_mask",  128'(po_block_mask), 128'(em));
    pulse_done();
    if (last) exp_idx = 0;
    else if (exp_idx == 255) exp_ovf = 1'b1;
    else exp_idx++;
    chk("done_ready", 128'(po_byte_ready), 128'(!exp_ovf));
    chk("done_busy",  128'(po_busy), 128'(0));
    chk("done_idx",   128'(po_block_idx), 128'(exp_idx));
    chk("done_ovf",   128'(po_overflow), 128'(exp_ovf));
    chk("done_mask",  128'(po_block_mask), 128'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    bit last;
    pi_rst        = 1'b1;
    pi_byte_data  = 8'h00;
    pi_byte_valid = 1'b0;
    pi_byte_last  = 1'b0;
    pi_done       = 1'b0;

    // Reset: outputs zero even with a byte offered.
    tick();
    pi_byte_valid = 1'b1;
    tick();
    chk_all_zero("rst");
    pi_byte_valid = 1'b0;
    pi_rst = 1'b0;
    tick();
    chk("post_rst_ready", 128'(po_byte_ready), 128'(1));
    chk("post_rst_idx",   128'(po_block_idx), 128'(0));

    // Full block 00..0F, no last.
    for (int i = 0; i < 16; i++) blk[i] = 8'(i);
    run_block(16, 1'b0, 10, 1'b0, 1'b0);

    // Partial final block.
    blk[0] = 8'hAA; blk[1] = 8'hBB; blk[2] = 8'hCC;
    run_block(3, 1'b1, 4, 1'b0, 1'b0);

    // Spurious done in FILL, then in the ISSUE cycle.
    pulse_done();
    chk("spur_fill_ready", 128'(po_byte_ready), 128'(1));
    chk("spur_fill_mask",  128'(po_block_mask), 128'(0));
    chk("spur_fill_busy",  128'(po_busy), 128'(0));
    fill_random();
    run_block(16, 1'b0, 6, 1'b1, 1'b0);

    // Backpressure: 0x55 held through WAIT becomes byte 0 of the next block.
    fill_random();
    run_block(16, 1'b0, 5, 1'b0, 1'b1);
    fill_random();
    blk[0] = 8'h55;
    run_block(5, 1'b1, 3, 1'b0, 1'b0);

    // Random mix of lengths, last flags and encryption times.
    for (int n = 0; n < 30; n++) begin
      fill_random();
      len  = $urandom_range(1, 16);
      last = (len < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      run_block(len, last, $urandom_range(0, 8), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset while waiting for done; late done is ignored.
    fill_random();
    for (int i = 0; i < 16; i++) send_byte(blk[i], 1'b0);
    tick();
    chk("midrst_busy", 128'(po_busy), 128'(1));
    pi_rst = 1'b1;
    tick();
    chk_all_zero("midrst");
    tick();
    pi_rst = 1'b0;
    exp_idx = 0;
    exp_ovf = 1'b0;
    pulse_done();
    chk("midrst_ready", 128'(po_byte_ready), 128'(1));
    chk("midrst_idx",   128'(po_block_idx), 128'(0));
    chk("midrst_mask",  128'(po_block_mask), 128'(0));
    chk("midrst_busy2", 128'(po_busy), 128'(0));

    // Index exhaustion: 256 full blocks without last.
    for (int n = 0; n < 256; n++) begin
      fill_random();
      run_block(16, 1'b0, $urandom_range(0, 2), 1'b0, 1'b0);
    end
    pi_byte_valid = 1'b1;
    pi_byte_data  = 8'h77;
    for (int c = 0; c < 25; c++) begin
      chk("halt_ready", 128'(po_byte_ready), 128'(0));
      chk("halt_ovf",   128'(po_overflow), 128'(1));
      tick();
    end
    chk("halt_mask", 128'(po_block_mask), 128'(0));
    pi_byte_valid = 1'b0;
    pi_rst = 1'b1;
    tick();
    chk_all_zero("halt_rst");
    pi_rst = 1'b0;
    exp_idx = 0;
    exp_ovf = 1'b0;
    tick();
    chk("halt_clr_ovf",   128'(po_overflow), 128'(0));
    chk("halt_clr_idx",   128'(po_block_idx), 128'(0));
    chk("halt_clr_ready", 128'(po_byte_ready), 128'(1));
    fill_random();
    run_block(16, 1'b1, 2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
